sobel_frame_ctrl: RTL and testbench

- Frame-level sequencer for the Sobel front end: line buffers, 3x3 window shift register and border zero-masking.
- Accepts a raster pixel stream through a valid/ready handshake and drives the window shift enable and the line-buffer write enable.
- After the last pixel of a frame, injects zero "flush" pixels so the bottom row of windows is produced.
- Emits per-window valid, centre row/column and border flags, so downstream masking and the gradient stage need no counters of their own.

---
 rtl/sobel_frame_ctrl.sv | 157 +++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// ---------------------------------------------------------------------------
// sobel_frame_ctrl
//
// Frame-level sequencer for the Sobel front end (line buffers, 3x3 window
// shift register, border masking). Accepts a raster pixel stream over a
// valid/ready handshake and drives the shift / line-buffer write enables.
// After the last pixel of a frame it injects COLS+1 zero flush pixels so the
// bottom row of windows completes. It reports, per window, a valid strobe,
// the centre row/column and the border flags of the centre pixel.
//
// Optional build macro: SOBEL_CTRL_AUTOSTART_EN
//   defined   : DONE returns straight to LOAD, frames stream back-to-back
//   undefined : DONE returns to IDLE, each frame needs a start_i pulse
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         begin a frame (sampled only in IDLE)
//   pix_i/pix_valid_i/pix_ready_o  incoming raster pixel handshake
//   stall_i         downstream backpressure, freezes all shifting
//   pix_o           pixel into line buffer 0 / window (0 during flush)
//   shift_en_o      advance line buffers and window registers
//   lb_wr_en_o      line-buffer write enable (same as shift_en_o)
//   win_valid_o     window centred at (row_o, col_o) is complete
//   row_o, col_o    centre coordinates of the current window
//   border_o        {top, bottom, left, right} flags of the centre pixel
//   busy_o          controller is not idle
//   frame_done_o    one-cycle pulse after the final window
// ---------------------------------------------------------------------------
module sobel_frame_ctrl #(
  parameter int ROWS = 5,
  parameter int COLS = 6,
  parameter int CW   = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [7:0]    pix_i,
  input  logic          pix_valid_i,
  output logic          pix_ready_o,
  input  logic          stall_i,
  output logic [7:0]    pix_o,
  output logic          shift_en_o,
  output logic          lb_wr_en_o,
  output logic          win_valid_o,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic [3:0]    border_o,
  output logic          busy_o,
  output logic          frame_done_o
);

  localparam int NPIX   = ROWS * COLS;
  localparam int SC_END = NPIX + COLS + 1;
  localparam int SCW    = $clog2(SC_END + 1);

  localparam logic [SCW-1:0] SC_LAST_PIX   = SCW'(NPIX - 1);
  localparam logic [SCW-1:0] SC_LAST_FLUSH = SCW'(SC_END - 1);
  localparam logic [SCW-1:0] SC_WIN_FIRST  = SCW'(COLS);
  localparam logic [SCW-1:0] SC_WIN_END    = SCW'(NPIX + COLS);
  localparam logic [CW-1:0]  ROW_LAST      = CW'(ROWS - 1);
  localparam logic [CW-1:0]  COL_LAST      = CW'(COLS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t         state, state_nxt;
  logic [SCW-1:0] sc;
  logic           accept;
  logic           flush_shift;
  logic           shift_en;
  logic           win_hit_p0;
  logic [CW-1:0]  nxt_row, nxt_col;
  logic           win_vld_p1;
  logic [CW-1:0]  row_p1, col_p1;
  logic [3:0]     border_p1;

  function automatic logic [3:0] border_flags(input logic [CW-1:0] r,
                                              input logic [CW-1:0] c);
    return {r == '0, r == ROW_LAST, c == '0, c == COL_LAST};
  endfunction

  always_comb begin
    state_nxt   = state;
    pix_ready_o = (state == LOAD) && !stall_i;
    accept      = pix_valid_i && pix_ready_o;
    flush_shift = (state == FLUSH) && !stall_i;
    shift_en    = accept || flush_shift;
    case (state)
      IDLE:  if (start_i) state_nxt = LOAD;
      LOAD:  if (accept && sc == SC_LAST_PIX) state_nxt = FLUSH;
      FLUSH: if (flush_shift && sc == SC_LAST_FLUSH) state_nxt = DONE;
      DONE: begin
`ifdef SOBEL_CTRL_AUTOSTART_EN
        state_nxt = LOAD;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // sc counts shifts within the frame; cleared whenever a new frame can begin.
  always_ff @(posedge clk) begin
    if (rst)                                sc <= '0;
    else if (state == IDLE || state == DONE) sc <= '0;
    else if (shift_en)                      sc <= sc + SCW'(1);
  end

  // Stage p0: the shift that brings sc into COLS+1..NPIX+COLS completes the
  // window for raster index sc-COLS. The final flush shift only drains the
  // window pipeline and produces no window of its own.
  assign win_hit_p0 = shift_en && (sc >= SC_WIN_FIRST) && (sc < SC_WIN_END);

  // Stage p1: registered window strobe with its centre coordinates.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_vld_p1 <= 1'b0;
      row_p1     <= '0;
      col_p1     <= '0;
      border_p1  <= '0;
      nxt_row    <= '0;
      nxt_col    <= '0;
    end else begin
      win_vld_p1 <= win_hit_p0;
      if (state == IDLE || state == DONE) begin
        nxt_row <= '0;
        nxt_col <= '0;
      end else if (win_hit_p0) begin
        row_p1    <= nxt_row;
        col_p1    <= nxt_col;
        border_p1 <= border_flags(nxt_row, nxt_col);
        if (nxt_col == COL_LAST) begin
          nxt_col <= '0;
          nxt_row <= (nxt_row == ROW_LAST) ? '0 : nxt_row + CW'(1);
        end else begin
          nxt_col <= nxt_col + CW'(1);
        end
      end
    end
  end

  assign pix_o        = accept ? pix_i : 8'h00;
  assign shift_en_o   = shift_en;
  assign lb_wr_en_o   = shift_en;
  assign win_valid_o  = win_vld_p1;
  assign row_o        = row_p1;
  assign col_o        = col_p1;
  assign border_o     = border_p1;
  assign busy_o       = (state != IDLE);
  assign frame_done_o = (state == DONE);

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sobel_frame_ctrl
//
// Scoreboard bench for sobel_frame_ctrl (default build). Each frame pushes
// the expected shifted pixels and the expected window sequence (centre
// row/col/border derived from raster index) into queues; a negedge monitor
// pops and compares whenever the DUT shifts or presents a window.
// ---------------------------------------------------------------------------
module tb_sobel_frame_ctrl;

  localparam int ROWS   = 5;
  localparam int COLS   = 6;
  localparam int CW     = 10;
  localparam int NPIX   = ROWS * COLS;
  localparam int NSHIFT = NPIX + COLS + 1;

  logic          clk;
  logic          rst;
  logic          start_i;
  logic [7:0]    pix_i;
  logic          pix_valid_i;
  logic          pix_ready_o;
  logic          stall_i;
  logic [7:0]    pix_o;
  logic          shift_en_o;
  logic          lb_wr_en_o;
  logic          win_valid_o;
  logic [CW-1:0] row_o;
  logic [CW-1:0] col_o;
  logic [3:0]    border_o;
  logic          busy_o;
  logic          frame_done_o;

  sobel_frame_ctrl #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pix_i(pix_i),
    .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o), .stall_i(stall_i),
    .pix_o(pix_o), .shift_en_o(shift_en_o), .lb_wr_en_o(lb_wr_en_o),
    .win_valid_o(win_valid_o), .row_o(row_o), .col_o(col_o),
    .border_o(border_o), .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         row;
    int         col;
    logic [3:0] border;
  } win_t;

  win_t       exp_win[$];
  logic [7:0] exp_pix[$];
  win_t       w;
  int         n_chk = 0;
  int         n_err = 0;
  int         shift_cnt = 0;
  int         win_cnt = 0;
  int         done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every shifted pixel and every window against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      chk("lb_wr_en", int'(lb_wr_en_o), int'(shift_en_o));
      if (stall_i) begin
        chk("stall_ready", int'(pix_ready_o), 0);
        chk("stall_shift", int'(shift_en_o), 0);
      end
      if (win_valid_o) begin
        if (exp_win.size() == 0) chk("win_unexpected", 1, 0);
        else begin
          w = exp_win.pop_front();
          chk("win_row", int'(row_o), w.row);
          chk("win_col", int'(col_o), w.col);
          chk("win_border", int'(border_o), int'(w.border));
          chk("win_shift_no", shift_cnt, win_cnt + COLS + 1);
        end
        win_cnt++;
      end
      if (shift_en_o) begin
        if (exp_pix.size() == 0) chk("shift_unexpected", 1, 0);
        else chk("pix_o", int'(pix_o), int'(exp_pix.pop_front()));
        shift_cnt++;
      end else begin
        chk("pix_o_idle", int'(pix_o), 0);
      end
      if (frame_done_o) done_cnt++;
    end
  end

  // mode 0: valid always, 1: directed stalls, 2: valid every other cycle,
  // 3: random valid/stall plus stray start_i, 4: valid always, abort at abort_at
  task automatic run_frame(input int mode, input int abort_at);
    logic [7:0] pix [NPIX];
    win_t       e;
    int         p;
    int         done_at;
    for (int i = 0; i < NPIX; i++) pix[i] = (mode == 0) ? 8'(i + 1) : 8'($urandom);
    @(posedge clk); #1;
    start_i = 1'b1; pix_valid_i = 1'b0; stall_i = 1'b0;
    shift_cnt = 0; win_cnt = 0; done_cnt = 0;
    for (int i = 0; i < NPIX; i++) exp_pix.push_back(pix[i]);
    for (int i = 0; i <= COLS; i++) exp_pix.push_back(8'h00);
    for (int j = 0; j < NPIX; j++) begin
      e.row = j / COLS;
      e.col = j % COLS;
      e.border = {e.row == 0, e.row == ROWS - 1, e.col == 0, e.col == COLS - 1};
      exp_win.push_back(e);
    end
    p = 0;
    done_at = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      start_i = (mode == 3) ? ($urandom_range(0, 7) == 0) : 1'b0;
      case (mode)
        1: begin pix_valid_i = 1'b1; stall_i = (c inside {10, 11, 12, 36, 37}); end
        2: begin pix_valid_i = (c % 2 == 1); stall_i = 1'b0; end
        3: begin pix_valid_i = ($urandom_range(0, 3) != 0); stall_i = ($urandom_range(0, 4) == 0); end
        default: begin pix_valid_i = 1'b1; stall_i = 1'b0; end
      endcase
      if (p >= NPIX) pix_valid_i = 1'b0;
      pix_i = pix_valid_i ? pix[p] : 8'($urandom);
      @(negedge clk);
      if (c == 1) chk("ready_after_start", int'(pix_ready_o), int'(!stall_i));
      if (pix_valid_i && pix_ready_o) p++;
      if (abort_at > 0 && p == abort_at) begin
        done_at = -2;
        break;
      end
      if (frame_done_o) begin
        done_at = c;
        break;
      end
    end
    start_i = 1'b0;
    if (done_at == -2) return;
    pix_valid_i = 1'b0;
    stall_i = 1'b0;
    chk("frame_done_seen", int'(done_at > 0), 1);
    if (mode == 0) chk("done_latency", done_at, NSHIFT + 1);
    if (mode == 1) chk("done_latency_stall", done_at, NSHIFT + 1 + 5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_after_done", int'(busy_o), 0);
    chk("done_one_cycle", int'(frame_done_o), 0);
    chk("shift_total", shift_cnt, NSHIFT);
    chk("win_total", win_cnt, NPIX);
    chk("done_pulses", done_cnt, 1);
    chk("win_queue_empty", exp_win.size(), 0);
    chk("pix_queue_empty", exp_pix.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, int'(pix_ready_o), 0);
    chk({tag, "_shift"}, int'(shift_en_o), 0);
    chk({tag, "_lbwr"}, int'(lb_wr_en_o), 0);
    chk({tag, "_pix"}, int'(pix_o), 0);
    chk({tag, "_win"}, int'(win_valid_o), 0);
    chk({tag, "_row"}, int'(row_o), 0);
    chk({tag, "_col"}, int'(col_o), 0);
    chk({tag, "_border"}, int'(border_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_done"}, int'(frame_done_o), 0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; pix_i = 8'h00; pix_valid_i = 1'b0; stall_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    run_frame(0, 0);
    run_frame(1, 0);
    run_frame(2, 0);

    // Abort mid-frame with reset, then confirm a clean restart.
    run_frame(4, 15);
    @(posedge clk); #1;
    rst = 1'b1; pix_valid_i = 1'b0;
    exp_win.delete();
    exp_pix.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    run_frame(0, 0);

    for (int k = 0; k < 4; k++) run_frame(3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
